// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: the sequencer state
// encoding, bus widths, default parameter values and a small index helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    CHECK,
    FIN
  } state_t;

  localparam int ADDR_W  = 16;
  localparam int CYCLE_W = 32;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_INSTR_WORDS = 256;
  localparam int DEF_DATA_WORDS  = 256;
  localparam int DEF_RUN_LIMIT   = 100000;
  localparam int DEF_CHECK_WORDS = 16;

  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  // Index of the final word of a block holding 'words' entries
  function automatic logic [ADDR_W-1:0] last_index(input int words);
    return ADDR_W'(words - 1);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Image source handshake plus memory write/readback bus. The loader
// drives this as master; the source/memory side connects as slave.
interface boot_loader_if #(
  parameter int DATA_W = 32
);

  logic                              src_req;
  logic                              src_sel;
  logic [boot_loader_pkg::ADDR_W-1:0] src_addr;
  logic                              src_valid;
  logic [DATA_W-1:0]                 src_rdata;
  logic                              instr_we;
  logic                              data_we;
  logic [boot_loader_pkg::ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]                 mem_wdata;
  logic [DATA_W-1:0]                 chk_rdata;

  modport master (
    output src_req, src_sel, src_addr,
    input  src_valid, src_rdata,
    output instr_we, data_we, mem_addr, mem_wdata,
    input  chk_rdata
  );

  modport slave (
    input  src_req, src_sel, src_addr,
    output src_valid, src_rdata,
    input  instr_we, data_we, mem_addr, mem_wdata,
    output chk_rdata
  );

endinterface

// File: rtl/boot_src_fetch.sv
// Source fetch engine: holds a word request with a stable select/index
// until the source answers, then advances. A launch restarts the index at 0
// for a new block; the request drops after the block's last word.
module boot_src_fetch
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              launch,
  input  logic              launch_sel,
  input  logic [ADDR_W-1:0] launch_last,
  input  logic              src_valid,
  output logic              src_req,
  output logic              src_sel,
  output logic [ADDR_W-1:0] src_addr,
  output logic              accept,
  output logic              last_word
);

  logic [ADDR_W-1:0] last_idx;

  assign accept    = src_req & src_valid;
  assign last_word = (src_addr == last_idx);

  // Request hold and index counter; a launch wins over a same-cycle accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_req  <= 1'b0;
      src_sel  <= SEL_INSTR;
      src_addr <= '0;
      last_idx <= '0;
    end else if (launch) begin
      src_req  <= 1'b1;
      src_sel  <= launch_sel;
      src_addr <= '0;
      last_idx <= launch_last;
    end else if (accept) begin
      if (last_word) begin
        src_req  <= 1'b0;
        src_addr <= '0;
      end else begin
        src_addr <= src_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader sequencer: copies the instruction and data images into CPU
// memories, releases the CPU, counts run cycles until halt or timeout and,
// when BOOT_LOADER_VERIFY_EN is defined, reads back the first data words
// against the source image and flags any mismatch.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int INSTR_WORDS = DEF_INSTR_WORDS,
  parameter int DATA_WORDS  = DEF_DATA_WORDS,
  parameter int RUN_LIMIT   = DEF_RUN_LIMIT,
  parameter int CHECK_WORDS = DEF_CHECK_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  boot_loader_if.master      bus,
  output logic               cpu_reset,
  input  logic               halt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               fail,
  output logic [CYCLE_W-1:0] cycles
);

  localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(RUN_LIMIT);

  state_t            state;
  logic              launch;
  logic              launch_sel;
  logic [ADDR_W-1:0] launch_last;
  logic              accept;
  logic              last_word;
  logic [CYCLE_W-1:0] cycles_inc;

  boot_src_fetch u_fetch (
    .clk         (clk),
    .reset       (reset),
    .launch      (launch),
    .launch_sel  (launch_sel),
    .launch_last (launch_last),
    .src_valid   (bus.src_valid),
    .src_req     (bus.src_req),
    .src_sel     (bus.src_sel),
    .src_addr    (bus.src_addr),
    .accept      (accept),
    .last_word   (last_word)
  );

  // The write strobe must coincide with the accepted source word
  assign bus.instr_we  = (state == LOAD_I) & accept;
  assign bus.data_we   = (state == LOAD_D) & accept;
  assign bus.mem_addr  = bus.src_addr;
  assign bus.mem_wdata = bus.src_rdata;

  assign cycles_inc = (cycles == '1) ? cycles : cycles + 1'b1;

  // Decide when the fetch engine starts a new block and which one
  always_comb begin
    launch      = 1'b0;
    launch_sel  = SEL_INSTR;
    launch_last = last_index(INSTR_WORDS);
    case (state)
      IDLE, FIN: begin
        if (start) launch = 1'b1;
      end
      LOAD_I: begin
        if (accept && last_word) begin
          launch      = 1'b1;
          launch_sel  = SEL_DATA;
          launch_last = last_index(DATA_WORDS);
        end
      end
`ifdef BOOT_LOADER_VERIFY_EN
      RUN: begin
        if (halt) begin
          launch      = 1'b1;
          launch_sel  = SEL_DATA;
          launch_last = last_index(CHECK_WORDS);
        end
      end
`endif
      default: ;
    endcase
  end

`ifdef BOOT_LOADER_VERIFY_EN
  logic fail_q;
  assign fail = fail_q;
`else
  logic unused_chk;
  assign unused_chk = ^bus.chk_rdata;
  assign fail = 1'b0;
`endif

  // Sequencer with registered CPU reset and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
`ifdef BOOT_LOADER_VERIFY_EN
      fail_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state   <= LOAD_I;
            busy    <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
`ifdef BOOT_LOADER_VERIFY_EN
            fail_q  <= 1'b0;
`endif
          end
        end
        LOAD_I: begin
          if (accept && last_word) state <= LOAD_D;
        end
        LOAD_D: begin
          if (accept && last_word) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end
        end
        RUN: begin
          cycles <= cycles_inc;
          if (halt) begin
            cpu_reset <= 1'b1;
`ifdef BOOT_LOADER_VERIFY_EN
            state     <= CHECK;
`else
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end else if (cycles_inc == LIMIT) begin
            state     <= FIN;
            cpu_reset <= 1'b1;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
`ifdef BOOT_LOADER_VERIFY_EN
        CHECK: begin
          if (accept) begin
            if (bus.src_rdata != bus.chk_rdata) fail_q <= 1'b1;
            if (last_word) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: image source model, data memory
// readback model and a write scoreboard. Runs the CHECK scenario only when
// BOOT_LOADER_VERIFY_EN is defined.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int DWS = 2;
  localparam int RL  = 50;
  localparam int CW  = 8;

  typedef struct packed {
    logic        is_data;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_reset, busy, done, timeout, fail;
  logic [31:0] cycles;

  int   tests = 0;
  int   fails = 0;
  int   valid_mode = 0;
  int   phase = 0;
  logic corrupt = 1'b0;
  int   strobe_cnt = 0;
  int   accept_cnt = 0;
  logic check_stable = 1'b0;
  logic prev_hold = 1'b0;
  logic prev_sel = 1'b0;
  logic [15:0] prev_addr = '0;
  wr_t  sb[$];
  wr_t  exp_w, got_w;

  boot_loader_if #(.DATA_W(DW)) bus();

  boot_loader #(
    .DATA_W(DW), .INSTR_WORDS(IW), .DATA_WORDS(DWS),
    .RUN_LIMIT(RL), .CHECK_WORDS(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .halt(halt), .busy(busy), .done(done),
    .timeout(timeout), .fail(fail), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] image(input logic sel, input logic [15:0] addr);
    return {sel ? 16'hDA7A : 16'h1157, addr ^ 16'h00A5};
  endfunction

  assign bus.src_rdata = image(bus.src_sel, bus.src_addr);
  assign bus.chk_rdata = (corrupt && bus.mem_addr == 16'd5) ? 32'hDEADBEEF
                                                            : image(1'b1, bus.mem_addr);

  // Source valid pattern: always ready, or ready every third cycle
  initial begin
    bus.src_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      bus.src_valid = (valid_mode == 0) ? 1'b1 : (phase % 3 == 0);
    end
  end

  // Scoreboard pop on every write strobe, plus request stability watch
  always @(negedge clk) begin
    if (reset) begin
      if (bus.instr_we || bus.data_we) begin
        strobe_cnt++;
        tests++;
        if (bus.instr_we && bus.data_we) begin
          fails++;
          $display("[TB] FAIL strobe_onehot: instr_we=1 data_we=1 at addr %0d", bus.mem_addr);
        end else if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb_unexpected: data_we=%0b addr=%0d wdata=%h with nothing expected",
                   bus.data_we, bus.mem_addr, bus.mem_wdata);
        end else begin
          exp_w = sb.pop_front();
          got_w = '{is_data: bus.data_we, addr: bus.mem_addr, data: bus.mem_wdata};
          if (got_w !== exp_w) begin
            fails++;
            $display("[TB] FAIL sb_write: got data=%0b addr=%0d wdata=%h, want data=%0b addr=%0d wdata=%h",
                     got_w.is_data, got_w.addr, got_w.data, exp_w.is_data, exp_w.addr, exp_w.data);
          end
        end
      end
      if (bus.src_req && bus.src_valid) accept_cnt++;
      if (check_stable && prev_hold) begin
        tests++;
        if ({bus.src_req, bus.src_sel, bus.src_addr} !== {1'b1, prev_sel, prev_addr}) begin
          fails++;
          $display("[TB] FAIL req_stable: got req=%0b sel=%0b addr=%0d, want req=1 sel=%0b addr=%0d",
                   bus.src_req, bus.src_sel, bus.src_addr, prev_sel, prev_addr);
        end
      end
      prev_hold = bus.src_req && !bus.src_valid;
      prev_sel  = bus.src_sel;
      prev_addr = bus.src_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push_load_expect();
    sb.delete();
    for (int i = 0; i < IW; i++) sb.push_back('{1'b0, 16'(i), image(1'b0, 16'(i))});
    for (int i = 0; i < DWS; i++) sb.push_back('{1'b1, 16'(i), image(1'b1, 16'(i))});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_halt();
    @(posedge clk); #1 halt = 1'b1;
    @(posedge clk); #1 halt = 1'b0;
  endtask

  task automatic wait_for_run(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_reset) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_for_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cpu_reset, bus.src_req, bus.instr_we, bus.data_we, busy, done, timeout, fail} !== 8'b1000_0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b want 10000000",
               {cpu_reset, bus.src_req, bus.instr_we, bus.data_we, busy, done, timeout, fail});
    end
    tests++;
    if (cycles !== 32'd0) begin fails++; $display("[TB] FAIL reset_cycles: got %0d want 0", cycles); end
    tests++;
    if (bus.src_addr !== 16'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0d want 0", bus.src_addr); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_load_fast();
    logic [3:0] want;
    logic ok;
    valid_mode = 0;
    push_load_expect();
    pulse_start();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      want = {k <= 4, (k == 5 || k == 6), k < 7, 1'b1};
      tests++;
      if ({bus.instr_we, bus.data_we, cpu_reset, busy} !== want) begin
        fails++;
        $display("[TB] FAIL load_fast_cycle%0d: got iwe/dwe/cpu_rst/busy=%b want %b", k,
                 {bus.instr_we, bus.data_we, cpu_reset, busy}, want);
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL load_fast_sb: %0d writes missing, want 0", sb.size()); end
    wait_for_done(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL load_fast_done: done=0 want 1"); end
  endtask

  task automatic test_timeout();
    logic ok;
    int n;
    push_load_expect();
    pulse_start();
    wait_for_run(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL timeout_run: cpu_reset=1 want 0"); end
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    tests++;
    if (n != RL) begin fails++; $display("[TB] FAIL timeout_latency: got %0d run cycles want %0d", n, RL); end
    tests++;
    if ({timeout, done, cpu_reset, busy} !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL timeout_flags: got to/done/cpu_rst/busy=%b want 1110", {timeout, done, cpu_reset, busy});
    end
    tests++;
    if (cycles !== 32'(RL)) begin fails++; $display("[TB] FAIL timeout_cycles: got %0d want %0d", cycles, RL); end
  endtask

  task automatic test_halt();
    logic ok;
    valid_mode = 0;
    push_load_expect();
    pulse_start();
    wait_for_run(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL halt_run: cpu_reset=1 want 0"); end
    repeat (36) @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk); #1 halt = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_reset !== 1'b1) begin fails++; $display("[TB] FAIL halt_cpu_reset: got %0b want 1", cpu_reset); end
    wait_for_done(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL halt_done: done=0 want 1"); end
    tests++;
    if (cycles !== 32'd37) begin fails++; $display("[TB] FAIL halt_cycles: got %0d want 37", cycles); end
    tests++;
    if ({done, timeout, fail, busy} !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL halt_flags: got done/to/fail/busy=%b want 1000", {done, timeout, fail, busy});
    end
  endtask

  task automatic test_slow_valid();
    logic ok;
    valid_mode = 1;
    push_load_expect();
    strobe_cnt = 0;
    accept_cnt = 0;
    check_stable = 1'b1;
    pulse_start();
    wait_for_run(ok);
    check_stable = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL slow_run: cpu_reset=1 want 0"); end
    tests++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL slow_sb: %0d writes missing, want 0", sb.size()); end
    tests++;
    if (strobe_cnt != IW + DWS || accept_cnt != IW + DWS) begin
      fails++;
      $display("[TB] FAIL slow_counts: strobes=%0d accepts=%0d want %0d each", strobe_cnt, accept_cnt, IW + DWS);
    end
    pulse_halt();
    wait_for_done(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL slow_done: done=0 want 1"); end
  endtask

`ifdef BOOT_LOADER_VERIFY_EN
  task automatic test_verify();
    logic ok;
    int reads;
    valid_mode = 0;
    corrupt = 1'b1;
    push_load_expect();
    pulse_start();
    wait_for_run(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL verify_run: cpu_reset=1 want 0"); end
    pulse_halt();
    reads = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.src_req && bus.src_valid) begin
        tests++;
        if (bus.src_sel !== 1'b1 || bus.mem_addr !== 16'(reads)) begin
          fails++;
          $display("[TB] FAIL verify_addr: got sel=%0b addr=%0d want sel=1 addr=%0d", bus.src_sel, bus.mem_addr, reads);
        end
        reads++;
      end
    end
    tests++;
    if (reads != CW) begin fails++; $display("[TB] FAIL verify_reads: got %0d want %0d", reads, CW); end
    tests++;
    if ({fail, done, timeout} !== 3'b110) begin
      fails++;
      $display("[TB] FAIL verify_flags: got fail/done/to=%b want 110", {fail, done, timeout});
    end
    corrupt = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic ok;
    logic found;
    valid_mode = 1;
    push_load_expect();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.src_req && bus.src_sel && bus.src_addr == 16'd1) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("[TB] FAIL midreset_reach: LOAD_D index 1 not seen"); end
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({cpu_reset, bus.src_req, bus.instr_we, bus.data_we, busy, done, timeout, fail} !== 8'b1000_0000) begin
      fails++;
      $display("[TB] FAIL midreset_flags: got %b want 10000000",
               {cpu_reset, bus.src_req, bus.instr_we, bus.data_we, busy, done, timeout, fail});
    end
    tests++;
    if (cycles !== 32'd0 || bus.mem_addr !== 16'd0) begin
      fails++;
      $display("[TB] FAIL midreset_state: cycles=%0d addr=%0d want 0 0", cycles, bus.mem_addr);
    end
    sb.delete();
    @(posedge clk); #1 reset = 1'b1;
    valid_mode = 0;
    push_load_expect();
    pulse_start();
    @(negedge clk);
    tests++;
    if ({bus.instr_we, bus.src_sel, bus.mem_addr} !== {1'b1, 1'b0, 16'd0}) begin
      fails++;
      $display("[TB] FAIL midreset_reload: got iwe=%0b sel=%0b addr=%0d want 1 0 0",
               bus.instr_we, bus.src_sel, bus.mem_addr);
    end
    wait_for_run(ok);
    tests++;
    if (!ok || sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL midreset_load: run=%0b missing=%0d want 1 0", ok, sb.size());
    end
    pulse_halt();
    wait_for_done(ok);
  endtask

  initial begin
    test_reset();
    test_load_fast();
    test_timeout();
    test_halt();
    test_slow_valid();
`ifdef BOOT_LOADER_VERIFY_EN
    test_verify();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
